// File: rtl/sigma_delta_pkg.sv
// Shared definitions for the sigma-delta link: window sizing, result
// saturation and the decoder enable-control state type.
package sigma_delta_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of enabled cycles in one decode window for a given value width.
  function automatic int unsigned win_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

  // Clamp a window ones-count to the largest representable value.
  // An all-ones window counts win_len(width), one more than fits.
  function automatic int unsigned sat_count(input int unsigned count,
                                            input int unsigned width);
    if (count >= win_len(width)) begin
      return win_len(width) - 32'd1;
    end
    return count;
  endfunction

endpackage

// File: rtl/sigma_delta_decoder.sv
// Boxcar decoder for a first-order sigma-delta bitstream: counts ones over
// 2**VALUE_WIDTH enabled cycles and offers each window result on a
// single-entry valid/ready buffer, flagging results dropped while full.
module sigma_delta_decoder
  import sigma_delta_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sigma_delta,
  output logic [VALUE_WIDTH-1:0] value,
  output logic                   valid,
  input  logic                   ready,
  output logic                   overrun
);

  state_t                 state;
  logic [VALUE_WIDTH-1:0] win_cnt;
  logic [VALUE_WIDTH:0]   acc;

  logic                   last_sample;
  logic [VALUE_WIDTH:0]   result;
  logic [VALUE_WIDTH-1:0] result_sat;

  // Window-end detection and the saturated ones-count including this sample.
  always_comb begin
    last_sample = enable && (win_cnt == '1);
    result      = acc + {{VALUE_WIDTH{1'b0}}, sigma_delta};
    result_sat  = VALUE_WIDTH'(sat_count(32'(result), VALUE_WIDTH));
  end

  // Enable FSM, window counter/accumulator and the output buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      win_cnt <= '0;
      acc     <= '0;
      value   <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;

      // The first enabled cycle already samples with win_cnt = 0, so IDLE
      // and RUN share the accumulate path; leaving RUN drops the partial
      // window by clearing counter and accumulator.
      case (state)
        IDLE: if (enable) state <= RUN;
        RUN:  if (!enable) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (enable) begin
        win_cnt <= win_cnt + VALUE_WIDTH'(1);
        acc     <= last_sample ? '0 : result;
      end else begin
        win_cnt <= '0;
        acc     <= '0;
      end

      // Load when empty or being drained this cycle; otherwise drop and flag.
      if (last_sample) begin
        if (!valid || ready) begin
          value <= result_sat;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_decoder.sv
// Self-checking bench for sigma_delta_decoder (VALUE_WIDTH = 8).
module tb_sigma_delta_decoder;

  localparam int WIN = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sigma_delta = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] value;
  logic       valid;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  // Reference model: ones counted in the current window, buffer contents.
  int   m_samples = 0;
  int   m_ones = 0;
  int   m_value = 0;
  logic m_valid = 1'b0;
  logic m_overrun = 1'b0;

  // Loopback modulator phase accumulator.
  int core_acc = 0;

  sigma_delta_decoder #(.VALUE_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sigma_delta(sigma_delta),
    .value(value), .valid(valid), .ready(ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Advance one clock; model next state uses the inputs present before the edge.
  task automatic tick();
    int   n_samples, n_ones, n_value, res;
    logic n_valid, n_overrun, done;
    n_samples = m_samples; n_ones = m_ones; n_value = m_value;
    n_valid = m_valid; n_overrun = 1'b0; done = 1'b0; res = 0;
    if (reset) begin
      n_samples = 0; n_ones = 0; n_value = 0; n_valid = 1'b0;
    end else begin
      if (enable) begin
        n_samples = n_samples + 1;
        n_ones = n_ones + (sigma_delta === 1'b1 ? 1 : 0);
        if (n_samples == WIN) begin
          done = 1'b1;
          res = (n_ones > WIN - 1) ? WIN - 1 : n_ones;
          n_samples = 0; n_ones = 0;
        end
      end else begin
        n_samples = 0; n_ones = 0;
      end
      if (done) begin
        if (!m_valid || ready) begin n_value = res; n_valid = 1'b1; end
        else n_overrun = 1'b1;
      end else if (m_valid && ready) begin
        n_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    m_samples = n_samples; m_ones = n_ones; m_value = n_value;
    m_valid = n_valid; m_overrun = n_overrun;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; ready = 1'b0; sigma_delta = 1'b0;
    tick();
    reset = 1'b0;
    core_acc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; sigma_delta = 1'b1; ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks += 3;
    if (value !== 8'd0) begin failures++; $display("FAIL reset_value got=%0d exp=0", value); end
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    reset = 1'b0;
  endtask

  task automatic test_all_ones();
    enable = 1'b1; sigma_delta = 1'b1; ready = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      tick();
      checks += 3;
      if (valid !== m_valid) begin failures++; $display("FAIL ones_valid cyc=%0d got=%b exp=%b", i, valid, m_valid); end
      if (value !== 8'(m_value)) begin failures++; $display("FAIL ones_value cyc=%0d got=%0d exp=%0d", i, value, m_value); end
      if (overrun !== 1'b0) begin failures++; $display("FAIL ones_overrun cyc=%0d got=%b exp=0", i, overrun); end
    end
    checks += 2;
    if (valid !== 1'b1) begin failures++; $display("FAIL ones_end_valid got=%b exp=1", valid); end
    if (value !== 8'd255) begin failures++; $display("FAIL ones_saturate got=%0d exp=255", value); end
  endtask

  task automatic test_all_zeros();
    logic exp_v;
    sigma_delta = 1'b0; ready = 1'b1;
    for (int i = 0; i < 2 * WIN; i++) begin
      tick();
      exp_v = (i == WIN - 1) || (i == 2 * WIN - 1);
      checks += 2;
      if (valid !== exp_v) begin failures++; $display("FAIL zeros_valid cyc=%0d got=%b exp=%b", i, valid, exp_v); end
      if (exp_v && value !== 8'd0) begin failures++; $display("FAIL zeros_value cyc=%0d got=%0d exp=0", i, value); end
      if (overrun !== m_overrun) begin failures++; $display("FAIL zeros_overrun cyc=%0d got=%b exp=%b", i, overrun, m_overrun); end
    end
  endtask

  task automatic test_loopback();
    int m, s;
    do_reset();
    enable = 1'b1; ready = 1'b1;
    for (int i = 0; i < 8 * WIN; i++) begin
      m = (i < 4 * WIN) ? 64 : 200;
      s = core_acc + m;
      sigma_delta = (s >= 256);
      tick();
      core_acc = s % 256;
      checks += 1;
      if (valid !== m_valid || value !== 8'(m_value)) begin
        failures++; $display("FAIL loop_model cyc=%0d got=%b/%0d exp=%b/%0d", i, valid, value, m_valid, m_value);
      end
      if ((i % WIN) == WIN - 1) begin
        checks += 1;
        if (valid !== 1'b1 || value !== 8'(m)) begin
          failures++; $display("FAIL loop_decode cyc=%0d got=%b/%0d exp=1/%0d", i, valid, value, m);
        end
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    enable = 1'b1; ready = 1'b0; sigma_delta = 1'b1;
    for (int i = 0; i < 2 * WIN; i++) begin
      tick();
      checks += 3;
      if (valid !== m_valid) begin failures++; $display("FAIL ovr_valid cyc=%0d got=%b exp=%b", i, valid, m_valid); end
      if (value !== 8'(m_value)) begin failures++; $display("FAIL ovr_value cyc=%0d got=%0d exp=%0d", i, value, m_value); end
      if (overrun !== (i == 2 * WIN - 1)) begin failures++; $display("FAIL ovr_pulse cyc=%0d got=%b exp=%b", i, overrun, (i == 2 * WIN - 1)); end
    end
    checks += 1;
    if (value !== 8'd255) begin failures++; $display("FAIL ovr_held got=%0d exp=255", value); end
    enable = 1'b0;
    tick();
    checks += 2;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_one_cycle got=%b exp=0", overrun); end
    if (valid !== 1'b1) begin failures++; $display("FAIL ovr_still_valid got=%b exp=1", valid); end
    ready = 1'b1;
    tick();
    checks += 2;
    if (valid !== 1'b0) begin failures++; $display("FAIL ovr_drained got=%b exp=0", valid); end
    if (value !== 8'd255) begin failures++; $display("FAIL ovr_value_kept got=%0d exp=255", value); end
  endtask

  task automatic test_enable_gap();
    logic bits [WIN];
    int j; logic t;
    do_reset();
    enable = 1'b1; ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sigma_delta = 1'($urandom);
      tick();
      checks += 1;
      if (valid !== 1'b0) begin failures++; $display("FAIL gap_partial_valid cyc=%0d got=%b exp=0", i, valid); end
    end
    enable = 1'b0; sigma_delta = 1'bx;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks += 2;
      if (valid !== 1'b0) begin failures++; $display("FAIL gap_idle_valid cyc=%0d got=%b exp=0", i, valid); end
      if (overrun !== 1'b0) begin failures++; $display("FAIL gap_idle_overrun cyc=%0d got=%b exp=0", i, overrun); end
    end
    for (int i = 0; i < WIN; i++) bits[i] = (i < 37);
    for (int i = WIN - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = bits[i]; bits[i] = bits[j]; bits[j] = t;
    end
    enable = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      sigma_delta = bits[i];
      tick();
      checks += 1;
      if (valid !== (i == WIN - 1)) begin failures++; $display("FAIL gap_valid cyc=%0d got=%b exp=%b", i, valid, (i == WIN - 1)); end
    end
    checks += 1;
    if (value !== 8'd37) begin failures++; $display("FAIL gap_value got=%0d exp=37", value); end
  endtask

  task automatic test_midwindow_reset();
    int ones;
    do_reset();
    enable = 1'b1; ready = 1'b0;
    for (int i = 0; i < WIN + 50; i++) begin
      sigma_delta = 1'($urandom);
      tick();
    end
    checks += 1;
    if (valid !== 1'b1) begin failures++; $display("FAIL mrst_pre_valid got=%b exp=1", valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0; ready = 1'b1;
    checks += 3;
    if (valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%b exp=0", valid); end
    if (value !== 8'd0) begin failures++; $display("FAIL mrst_value got=%0d exp=0", value); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL mrst_overrun got=%b exp=0", overrun); end
    ones = 0;
    for (int i = 0; i < WIN; i++) begin
      sigma_delta = 1'($urandom);
      ones += int'(sigma_delta);
      tick();
      checks += 1;
      if (valid !== (i == WIN - 1)) begin failures++; $display("FAIL mrst_win_valid cyc=%0d got=%b exp=%b", i, valid, (i == WIN - 1)); end
    end
    checks += 1;
    if (value !== 8'(ones)) begin failures++; $display("FAIL mrst_win_value got=%0d exp=%0d", value, ones); end
  endtask

  task automatic test_back_to_back();
    int  dens;
    logic rdy_mode;
    do_reset();
    dens = 128; rdy_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i % WIN == 0) dens = $urandom_range(0, 256);
      if (i % 200 == 0) rdy_mode = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 1999) != 0);
      ready = rdy_mode ? 1'($urandom) : 1'b0;
      sigma_delta = ($urandom_range(0, 255) < dens);
      tick();
      checks += 3;
      if (valid !== m_valid) begin failures++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, valid, m_valid); end
      if (value !== 8'(m_value)) begin failures++; $display("FAIL b2b_value cyc=%0d got=%0d exp=%0d", i, value, m_value); end
      if (overrun !== m_overrun) begin failures++; $display("FAIL b2b_overrun cyc=%0d got=%b exp=%b", i, overrun, m_overrun); end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_loopback();
    test_overrun();
    test_enable_gap();
    test_midwindow_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sigma_delta_decoder.md
Name: sigma_delta_decoder

Overview:
- Receive end of the first-order sigma-delta link. Recovers the multi-bit value from the 1-bit stream produced by sigma_delta_core.
- Counts ones over a fixed window of 2**VALUE_WIDTH enabled clock cycles (boxcar accumulate-and-dump).
- Presents each window result on a single-entry valid/ready output buffer.
- Sits downstream of the modulator, or of a pin synchroniser, and feeds digital consumers and loopback checkers.

Parameters:
- VALUE_WIDTH, 8, output value width; the window length is 2**VALUE_WIDTH cycles.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  decoder enable; windows run only while high.
- sigma_delta  input  1  modulated bitstream, one sample per clk.
- value  output  VALUE_WIDTH  decoded window result.
- valid  output  1  value holds an unconsumed result.
- ready  input  1  consumer accepts value when valid and ready are both high.
- overrun  output  1  one-cycle pulse when a completed window result is dropped.

Behaviour:
- Reset, synchronous and active-high, has priority over everything else:
  - value = 0, valid = 0, overrun = 0.
  - Window counter = 0, accumulator = 0.
- Window counter:
  - VALUE_WIDTH bits wide, counting 0 .. 2**VALUE_WIDTH-1.
  - Increments on each cycle with enable = 1 and wraps to 0.
- Accumulator:
  - VALUE_WIDTH+1 bits wide.
  - On each enabled cycle that is not the last of a window: acc <= acc + sigma_delta.
- Last cycle of a window (enable = 1 and counter = 2**VALUE_WIDTH-1):
  - result = acc + sigma_delta, range 0 .. 2**VALUE_WIDTH.
  - Saturate to 2**VALUE_WIDTH-1 when result = 2**VALUE_WIDTH.
  - acc <= 0 in the same cycle; the next window starts immediately with no gap.
- Latency: value and valid update on the clock edge that samples the last bit of the window, so they are visible the cycle after that sample.
- Output buffer is a single entry:
  - Load is allowed when valid = 0, or when valid = 1 and ready = 1 in that same cycle (simultaneous consume and load; valid stays 1 with the new value).
  - If valid = 1 and ready = 0 when a result completes: the result is discarded, value and valid are unchanged, and overrun = 1 for exactly one cycle.
  - On a handshake with no new result: valid <= 0 and value holds its last data.
  - value is stable while valid = 1 and ready = 0.
- Enable control, states IDLE and RUN:
  - IDLE -> RUN on enable = 1. The first sample is taken in that cycle with counter = 0.
  - RUN -> IDLE on enable = 0. The counter and accumulator clear on the next edge and the partial window is discarded with no valid and no overrun.
  - The output buffer and handshake keep operating in IDLE, so a pending value can still be consumed.
- Alignment with sigma_delta_core: when both are enabled on the same cycle from reset, value = m is decoded exactly as m in every full window in which m is held constant.
- sigma_delta is sampled only when enable = 1; X on it while disabled has no effect.

Decomposition:
- Shared package sigma_delta_pkg holds:
  - the window-length function win_len(width) = 2**width;
  - the saturate function sat_count(count, width), used by the decoder and the scoreboard;
  - the state enum typedef {IDLE, RUN}.
- No sub-module: the counter, accumulator, output buffer and FSM are all small.

Test Plan (VALUE_WIDTH = 8):
1. reset released, enable = 1, sigma_delta = 1 for 256 cycles, ready = 1 -> valid pulses on the cycle after the 256th sample with value = 255 (saturated from 256); overrun = 0.
2. sigma_delta = 0 for 256 cycles -> value = 0, valid = 1 for one cycle; repeat a second window -> second result also 0 with no gap between windows.
3. Loopback from sigma_delta_core, both enabled on the same cycle, core value = 64 then 200, each held 4 windows -> every window fully inside a held value decodes exactly 64 or 200.
4. ready = 0 across two window ends with all-ones input -> first result 255 is held; overrun = 1 for one cycle at the second window end; after ready = 1, one handshake occurs, then valid = 0.
5. enable dropped after 100 samples, re-raised 10 cycles later, then a full window with 37 ones -> no valid for the partial window; the next result is value = 37.
6. reset asserted for one cycle while valid = 1 and in mid-window -> on the next cycle valid = 0, value = 0, overrun = 0; the following full window decodes correctly.
